// File: rtl/sseg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed active-low 7-segment bus; capture lands SETTLE_CYCLES+3 cycles after the bus settles.
// Passive sampler (no backpressure). Define SSEG_DP_CAPTURE_EN to capture decimal points and decode seg[6:0] only.
module sseg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 131072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [7:0]  seg,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic [3:0]  dp,
   output logic        frame_done,
   output logic        blank,
   output logic        pattern_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t        state;
   logic [3:0]    an_s1, an_s2;
   logic [7:0]    seg_s1, seg_s2;
   logic [11:0]   samp_prev;
   logic [11:0]   samp_held;
   logic [7:0]    settle_cnt;
   logic [TW-1:0] idle_cnt;
   logic [1:0]    last_idx;
   logic          have_last;

   logic [11:0]   samp;
   logic          one_hot;
   logic [1:0]    idx;
   logic [3:0]    dec_val;
   logic          dec_digit;
   logic          dec_blank;
   logic          capture_go;

   assign samp = {an_s2, seg_s2};

   always_comb begin
      one_hot = 1'b0;
      idx     = 2'd0;
      case (an_s2)
         4'b1110: begin one_hot = 1'b1; idx = 2'd0; end
         4'b1101: begin one_hot = 1'b1; idx = 2'd1; end
         4'b1011: begin one_hot = 1'b1; idx = 2'd2; end
         4'b0111: begin one_hot = 1'b1; idx = 2'd3; end
         default: ;
      endcase
   end

   // dec_digit: a recognised glyph; dec_blank: all segments dark; neither means undecodable.
   always_comb begin
      dec_val   = 4'hF;
      dec_digit = 1'b1;
      dec_blank = 1'b0;
      case (seg_s2[6:0])
         7'h40: dec_val = 4'h0;
         7'h79: dec_val = 4'h1;
         7'h24: dec_val = 4'h2;
         7'h30: dec_val = 4'h3;
         7'h19: dec_val = 4'h4;
         7'h12: dec_val = 4'h5;
         7'h02: dec_val = 4'h6;
         7'h78: dec_val = 4'h7;
         7'h00: dec_val = 4'h8;
         7'h10: dec_val = 4'h9;
         7'h09: dec_val = 4'hE;
         7'h7F: begin
            dec_val   = 4'h0;
            dec_digit = 1'b0;
            dec_blank = 1'b1;
         end
         default: dec_digit = 1'b0;
      endcase
`ifndef SSEG_DP_CAPTURE_EN
      if (!seg_s2[7]) begin
         dec_val   = 4'hF;
         dec_digit = 1'b0;
         dec_blank = 1'b0;
      end
`endif
   end

   // Results are registered on entry to CAPTURE so they are visible during the CAPTURE cycle.
   assign capture_go = (state == SETTLE) && one_hot && (samp == samp_prev) &&
                       (settle_cnt == SETTLE_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         an_s1       <= 4'hF;
         an_s2       <= 4'hF;
         seg_s1      <= 8'hFF;
         seg_s2      <= 8'hFF;
         samp_prev   <= 12'hFFF;
         samp_held   <= 12'hFFF;
         settle_cnt  <= 8'd0;
         idle_cnt    <= '0;
         last_idx    <= 2'd0;
         have_last   <= 1'b0;
         digits      <= 16'h0000;
         digit_valid <= 4'b0000;
         frame_done  <= 1'b0;
         blank       <= 1'b1;
         pattern_err <= 1'b0;
      end else begin
         an_s1      <= an;
         an_s2      <= an_s1;
         seg_s1     <= seg;
         seg_s2     <= seg_s1;
         samp_prev  <= samp;
         frame_done <= 1'b0;

         case (state)
            IDLE: begin
               if (one_hot) begin
                  state      <= SETTLE;
                  settle_cnt <= 8'd0;
                  idle_cnt   <= '0;
               end else if (idle_cnt != TIMEOUT_LAST) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end else begin
                  blank       <= 1'b1;
                  digit_valid <= 4'b0000;
                  have_last   <= 1'b0;
               end
            end

            SETTLE: begin
               if (!one_hot) begin
                  state      <= IDLE;
                  settle_cnt <= 8'd0;
               end else if (samp != samp_prev) begin
                  settle_cnt <= 8'd0;
               end else if (capture_go) begin
                  state                  <= CAPTURE;
                  settle_cnt             <= 8'd0;
                  samp_held              <= samp;
                  digits[{idx, 2'b00} +: 4] <= dec_val;
                  digit_valid[idx]       <= dec_digit;
                  blank                  <= 1'b0;
                  frame_done             <= have_last && (idx <= last_idx);
                  last_idx               <= idx;
                  have_last              <= 1'b1;
                  if (!dec_digit && !dec_blank)
                     pattern_err <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end

            CAPTURE: state <= HOLD;

            HOLD: begin
               // Compare against the captured sample so a change during CAPTURE is not lost.
               if (samp != samp_held) begin
                  state      <= one_hot ? SETTLE : IDLE;
                  settle_cnt <= 8'd0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef SSEG_DP_CAPTURE_EN
   logic [3:0] dp_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dp_q <= 4'b0000;
      else if (capture_go)
         dp_q[idx] <= ~seg_s2[7];
   end

   assign dp = dp_q;
`else
   assign dp = 4'b0000;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Randomised scoreboard bench for sseg_scan_decoder (default build, decimal-point capture disabled).
module tb_sseg_scan_decoder;
   localparam int S = 4;
   localparam int T = 256;
   localparam logic [7:0] GLYPH [11] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                         8'h82, 8'hF8, 8'h80, 8'h90, 8'h89};

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  an    = 4'hF;
   logic [7:0]  seg   = 8'hFF;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic [3:0]  dp;
   logic        frame_done;
   logic        blank;
   logic        pattern_err;

   sseg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .an          (an),
      .seg         (seg),
      .digits      (digits),
      .digit_valid (digit_valid),
      .dp          (dp),
      .frame_done  (frame_done),
      .blank       (blank),
      .pattern_err (pattern_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      bit          chk_pre;
      logic [15:0] pre;
      logic [15:0] dig;
      logic [3:0]  vld;
      logic        fd;
      logic        blk;
      logic        err;
   } item_t;

   item_t q[$];
   int checks = 0;
   int passed = 0;

   // Reference model: what the display should read once each glyph has been captured.
   logic [15:0] m_dig;
   logic [3:0]  m_vld;
   logic        m_blank, m_err, m_have;
   int          m_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
   endtask

   task automatic model_reset();
      m_dig = 16'h0; m_vld = 4'h0; m_blank = 1'b1; m_err = 1'b0; m_have = 1'b0; m_last = 0;
   endtask

   task automatic push_state(input int due);
      item_t it;
      it.due = due; it.chk_pre = 1'b0; it.pre = m_dig; it.dig = m_dig; it.vld = m_vld;
      it.fd = 1'b0; it.blk = m_blank; it.err = m_err;
      q.push_back(it);
   endtask

   task automatic exp_capture(input logic [3:0] a, input logic [7:0] s);
      item_t it;
      int idx = 0;
      logic [3:0] val = 4'hF;
      logic ok = 1'b0;
      logic bad = 1'b1;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      if (s == 8'hFF) begin
         val = 4'h0; bad = 1'b0;
      end else begin
         for (int k = 0; k < 11; k++)
            if (s == GLYPH[k]) begin
               val = (k == 10) ? 4'hE : 4'(k); ok = 1'b1; bad = 1'b0;
            end
      end
      it.due = cyc + S + 3; it.chk_pre = 1'b1; it.pre = m_dig;
      it.fd = m_have && (idx <= m_last);
      m_have = 1'b1; m_last = idx; m_blank = 1'b0;
      if (bad) m_err = 1'b1;
      m_dig[4*idx +: 4] = val;
      m_vld[idx] = ok;
      it.dig = m_dig; it.vld = m_vld; it.blk = m_blank; it.err = m_err;
      q.push_back(it);
   endtask

   task automatic step(input logic [3:0] a, input logic [7:0] s, input int len);
      an = a; seg = s;
      if ($countones(~a) == 1) exp_capture(a, s);
      repeat (len) @(posedge clk);
      #1;
   endtask

   task automatic idle_long();
      an = 4'hF;
      m_blank = 1'b1; m_vld = 4'h0; m_have = 1'b0;
      push_state(cyc + T + 19);
      repeat (T + 20) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() != 0 && q[0].chk_pre && q[0].due == cyc + 1)
         check("digits_before_capture", 32'(digits), 32'(q[0].pre));
      if (frame_done && !(q.size() != 0 && q[0].due == cyc && q[0].fd)) begin
         checks++;
         $display("FAIL unexpected_frame_done at cycle %0d: got 1, expected 0", cyc);
      end
      if (q.size() != 0 && q[0].due == cyc) begin
         check("digits",      32'(digits),      32'(q[0].dig));
         check("digit_valid", 32'(digit_valid), 32'(q[0].vld));
         check("dp",          32'(dp),          32'h0);
         check("frame_done",  32'(frame_done),  32'(q[0].fd));
         check("blank",       32'(blank),       32'(q[0].blk));
         check("pattern_err", 32'(pattern_err), 32'(q[0].err));
         void'(q.pop_front());
      end else if (q.size() != 0 && q[0].due < cyc) begin
         checks++;
         $display("FAIL missed_event: due cycle %0d, now %0d", q[0].due, cyc);
         void'(q.pop_front());
      end
   end

   initial begin
      model_reset();
      @(posedge clk); #1;
      push_state(cyc);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      step(4'b1110, 8'hC0, 20);

      for (int r = 0; r < 2; r++) begin
         step(4'b1110, 8'hF9, 64);
         step(4'b1101, 8'hA4, 64);
         step(4'b1011, 8'hB0, 64);
         step(4'b0111, 8'h99, 64);
      end

      idle_long();

      for (int r = 0; r < 3; r++) begin
         step(4'b1110, 8'hF9, 30);
         step(4'b1101, 8'h89, 30);
      end

      step(4'b1011, 8'hAA, 30);

      for (int n = 0; n < 40; n++) begin
         logic [3:0] a;
         logic [7:0] s;
         int k;
         do begin
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) != 0) ? 4'hF : 4'b1100;
            else a = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
            k = $urandom_range(0, 12);
            s = (k < 11) ? GLYPH[k] : ((k == 11) ? 8'hFF : 8'($urandom));
         end while ({a, s} == {an, seg});
         step(a, s, $urandom_range(S + 4, S + 20));
      end

      // Glitchy bus never settles, then reset lands mid-settle.
      an = 4'b1110;
      push_state(cyc + 15);
      for (int k = 0; k < 8; k++) begin
         seg = (k % 2 != 0) ? 8'hA4 : 8'hF9;
         repeat (2) @(posedge clk);
         #1;
      end
      seg = 8'hA4;
      reset = 1'b0;
      model_reset();
      push_state(cyc);
      seg = 8'hF9;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      exp_capture(4'b1110, 8'hF9);
      repeat (S + 10) @(posedge clk);
      #1;

      for (int w = 0; w < 200 && q.size() != 0; w++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: %0d events outstanding, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive identical synchronized samples of {an,seg} required before capture, range 1-255.
REQ-002 Parameter TIMEOUT_CYCLES, default 131072: cycles with no valid one-hot anode before the display is declared blank, range 2-2^24.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 an  input  4  active-low digit anodes from a multiplexed 7-segment driver.
REQ-006 seg  input  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-007 digits  output  16  captured nibbles, digit i at bits [4i+3:4i].
REQ-008 digit_valid  output  4  bit i set when digit i holds a decoded non-blank pattern.
REQ-009 dp  output  4  captured decimal points, active-high.
REQ-010 frame_done  output  1  one-cycle pulse on scan wrap-around.
REQ-011 blank  output  1  high while the display is considered dark.
REQ-012 pattern_err  output  1  sticky flag for an undecodable segment pattern.

Function
REQ-013 an and seg SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 FSM states SHALL be IDLE, SETTLE, CAPTURE, HOLD.
REQ-015 IDLE: synchronized an not exactly one bit low; any one-hot-low an -> SETTLE with stability counter cleared.
REQ-016 SETTLE: counter increments while synchronized {an,seg} equals previous sample; any change clears counter; counter reaching SETTLE_CYCLES -> CAPTURE; an leaving one-hot -> IDLE.
REQ-017 CAPTURE: lasts one cycle; writes digit index i (position of the low an bit); -> HOLD.
REQ-018 HOLD: stays while {an,seg} unchanged; any change -> SETTLE (one-hot an) or IDLE (otherwise).
REQ-019 Latency from a stable input change to digits update SHALL be SETTLE_CYCLES+3 clock cycles.
REQ-020 Decode (seg[6:0]): 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x09->E ("H"); pattern 0x79 ("1"/"I") SHALL always decode to 1.
REQ-021 seg[6:0]=0x7F SHALL write 0x0 to digit i and clear digit_valid[i] without error.
REQ-022 Any other pattern SHALL write 0xF, clear digit_valid[i], set pattern_err.
REQ-023 frame_done SHALL pulse in the CAPTURE cycle when i is less than or equal to the previously captured index; never on the first capture after reset or after blank.
REQ-024 Timeout counter SHALL count cycles in IDLE, clear on leaving IDLE; at TIMEOUT_CYCLES blank=1 and digit_valid=0000; blank SHALL clear on the next CAPTURE.
REQ-025 pattern_err SHALL clear only on reset.
REQ-026 Captured values SHALL persist until overwritten by a later capture of the same index or cleared by blank.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, synchronizers to 1s, all counters 0, digits=0x0000, digit_valid=0000, dp=0000, frame_done=0, blank=1, pattern_err=0.
REQ-028 reset asserted mid-SETTLE or mid-CAPTURE SHALL abort without partial update; first capture after release SHALL require a full settle period.

Configuration
REQ-029 Macro SSEG_DP_CAPTURE_EN defined: dp[i] SHALL capture ~seg[7] at CAPTURE; decoding SHALL use seg[6:0] only.
REQ-030 Macro SSEG_DP_CAPTURE_EN undefined: dp SHALL be tied to 0000; decoding SHALL use all 8 bits, and any pattern with seg[7]=0 SHALL be treated as undecodable (REQ-022).

Verification
REQ-031 Hold an=1110, seg=0xC0 for 20 cycles -> digits[3:0]=0x0, digit_valid[0]=1 exactly SETTLE_CYCLES+3 cycles after the change.
REQ-032 Scan an 1110/1101/1011/0111 with seg 0xF9/0xA4/0xB0/0x99, 64 cycles each, two rounds -> digits=0x4321, digit_valid=1111, one frame_done per wrap to digit 0.
REQ-033 Alternate an=1110 seg=0xF9, an=1101 seg=0x89 -> digits[7:0]=0xE1, frame_done on each return to digit 0, pattern_err=0.
REQ-034 Hold an=1111 for TIMEOUT_CYCLES after REQ-032 -> blank=1, digit_valid=0000, digits unchanged.
REQ-035 Drive seg=0xAA on an=1011 -> digits[11:8]=0xF, digit_valid[2]=0, pattern_err=1 until reset.
REQ-036 Toggle seg every 2 cycles with SETTLE_CYCLES=4, then assert reset mid-SETTLE -> no capture, all outputs at REQ-027 values.
